// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
// Bubbles clear only control bits; data/index fields always follow ID.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_RegDst_i,
    input  logic [1:0]        id_ALUOp_i,
    input  logic              id_ALUSrc_i,
    input  logic              id_RegWrite_i,
    input  logic              id_MemWrite_i,
    input  logic              id_MemRead_i,
    input  logic              id_MemtoReg_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic [5:0]        id_funct_i,
    output logic              ex_RegDst_o,
    output logic [1:0]        ex_ALUOp_o,
    output logic              ex_ALUSrc_o,
    output logic              ex_RegWrite_o,
    output logic              ex_MemWrite_o,
    output logic              ex_MemRead_o,
    output logic              ex_MemtoReg_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic [5:0]        ex_funct_o,
    output logic              stall_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    logic hz;
    logic bubble;

    // rs and rt are both compared regardless of format; false stalls are harmless
    assign hz = ex_MemRead_o & (ex_rt_o != 5'd0) &
                ((ex_rt_o == id_rs_i) | (ex_rt_o == id_rt_i));

    assign stall_o      = hz & ~hold_i & ~flush_i;
    assign pc_write_o   = ~stall_o;
    assign ifid_write_o = ~stall_o;
    assign bubble       = flush_i | hz;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_RegDst_o   <= 1'b0;
            ex_ALUOp_o    <= 2'b00;
            ex_ALUSrc_o   <= 1'b0;
            ex_RegWrite_o <= 1'b0;
            ex_MemWrite_o <= 1'b0;
            ex_MemRead_o  <= 1'b0;
            ex_MemtoReg_o <= 1'b0;
            ex_rs_data_o  <= '0;
            ex_rt_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_rs_o       <= 5'd0;
            ex_rt_o       <= 5'd0;
            ex_rd_o       <= 5'd0;
            ex_funct_o    <= 6'd0;
            bubble_cnt_o  <= '0;
        end else if (!hold_i) begin
            ex_rs_data_o <= id_rs_data_i;
            ex_rt_data_o <= id_rt_data_i;
            ex_imm_o     <= id_imm_i;
            ex_rs_o      <= id_rs_i;
            ex_rt_o      <= id_rt_i;
            ex_rd_o      <= id_rd_i;
            ex_funct_o   <= id_funct_i;
            if (bubble) begin
                ex_RegDst_o   <= 1'b0;
                ex_ALUOp_o    <= 2'b00;
                ex_ALUSrc_o   <= 1'b0;
                ex_RegWrite_o <= 1'b0;
                ex_MemWrite_o <= 1'b0;
                ex_MemRead_o  <= 1'b0;
                ex_MemtoReg_o <= 1'b0;
                if (bubble_cnt_o != {CNT_W{1'b1}}) begin
                    bubble_cnt_o <= bubble_cnt_o + 1'b1;
                end
            end else begin
                ex_RegDst_o   <= id_RegDst_i;
                ex_ALUOp_o    <= id_ALUOp_i;
                ex_ALUSrc_o   <= id_ALUSrc_i;
                ex_RegWrite_o <= id_RegWrite_i;
                ex_MemWrite_o <= id_MemWrite_i;
                ex_MemRead_o  <= id_MemRead_i;
                ex_MemtoReg_o <= id_MemtoReg_i;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage
// Small counter width so saturation is reachable in a few cycles.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int MAXC   = (1 << CNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              hold_i = 1'b0;
    logic              flush_i = 1'b0;
    logic              id_RegDst_i = 1'b0;
    logic [1:0]        id_ALUOp_i = 2'b00;
    logic              id_ALUSrc_i = 1'b0;
    logic              id_RegWrite_i = 1'b0;
    logic              id_MemWrite_i = 1'b0;
    logic              id_MemRead_i = 1'b0;
    logic              id_MemtoReg_i = 1'b0;
    logic [DATA_W-1:0] id_rs_data_i = '0;
    logic [DATA_W-1:0] id_rt_data_i = '0;
    logic [DATA_W-1:0] id_imm_i = '0;
    logic [4:0]        id_rs_i = 5'd0;
    logic [4:0]        id_rt_i = 5'd0;
    logic [4:0]        id_rd_i = 5'd0;
    logic [5:0]        id_funct_i = 6'd0;
    logic              ex_RegDst_o;
    logic [1:0]        ex_ALUOp_o;
    logic              ex_ALUSrc_o;
    logic              ex_RegWrite_o;
    logic              ex_MemWrite_o;
    logic              ex_MemRead_o;
    logic              ex_MemtoReg_o;
    logic [DATA_W-1:0] ex_rs_data_o;
    logic [DATA_W-1:0] ex_rt_data_o;
    logic [DATA_W-1:0] ex_imm_o;
    logic [4:0]        ex_rs_o;
    logic [4:0]        ex_rt_o;
    logic [4:0]        ex_rd_o;
    logic [5:0]        ex_funct_o;
    logic              stall_o;
    logic              pc_write_o;
    logic              ifid_write_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i),
        .id_RegDst_i(id_RegDst_i), .id_ALUOp_i(id_ALUOp_i), .id_ALUSrc_i(id_ALUSrc_i),
        .id_RegWrite_i(id_RegWrite_i), .id_MemWrite_i(id_MemWrite_i),
        .id_MemRead_i(id_MemRead_i), .id_MemtoReg_i(id_MemtoReg_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_funct_i(id_funct_i),
        .ex_RegDst_o(ex_RegDst_o), .ex_ALUOp_o(ex_ALUOp_o), .ex_ALUSrc_o(ex_ALUSrc_o),
        .ex_RegWrite_o(ex_RegWrite_o), .ex_MemWrite_o(ex_MemWrite_o),
        .ex_MemRead_o(ex_MemRead_o), .ex_MemtoReg_o(ex_MemtoReg_o),
        .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
        .stall_o(stall_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit        regDst;
        bit [1:0]  aluOp;
        bit        aluSrc, regWrite, memWrite, memRead, memtoReg;
        bit [31:0] rsData, rtData, imm;
        bit [4:0]  rs, rt, rd;
        bit [5:0]  funct;
        int        cnt;
    } exModel_t;

    exModel_t m = '{default: 0};
    int passCnt = 0;
    int totalCnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // A load in EX whose nonzero destination is a source of the ID instruction
    function automatic bit loadUse();
        return m.memRead && m.rt != 0 && (m.rt == id_rs_i || m.rt == id_rt_i);
    endfunction

    function automatic bit squash();
        return flush_i || loadUse();
    endfunction

    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m <= '{default: 0};
        end else if (!hold_i) begin
            m.rsData   <= id_rs_data_i;
            m.rtData   <= id_rt_data_i;
            m.imm      <= id_imm_i;
            m.rs       <= id_rs_i;
            m.rt       <= id_rt_i;
            m.rd       <= id_rd_i;
            m.funct    <= id_funct_i;
            m.regDst   <= squash() ? 1'b0 : id_RegDst_i;
            m.aluOp    <= squash() ? 2'b00 : id_ALUOp_i;
            m.aluSrc   <= squash() ? 1'b0 : id_ALUSrc_i;
            m.regWrite <= squash() ? 1'b0 : id_RegWrite_i;
            m.memWrite <= squash() ? 1'b0 : id_MemWrite_i;
            m.memRead  <= squash() ? 1'b0 : id_MemRead_i;
            m.memtoReg <= squash() ? 1'b0 : id_MemtoReg_i;
            m.cnt      <= (squash() && m.cnt < MAXC) ? m.cnt + 1 : m.cnt;
        end
    end

    always @(negedge clk_i) begin
        bit expStall;
        expStall = loadUse() && !hold_i && !flush_i;
        check("m_RegDst", ex_RegDst_o, m.regDst);
        check("m_ALUOp", ex_ALUOp_o, m.aluOp);
        check("m_ALUSrc", ex_ALUSrc_o, m.aluSrc);
        check("m_RegWrite", ex_RegWrite_o, m.regWrite);
        check("m_MemWrite", ex_MemWrite_o, m.memWrite);
        check("m_MemRead", ex_MemRead_o, m.memRead);
        check("m_MemtoReg", ex_MemtoReg_o, m.memtoReg);
        check("m_rs_data", ex_rs_data_o, m.rsData);
        check("m_rt_data", ex_rt_data_o, m.rtData);
        check("m_imm", ex_imm_o, m.imm);
        check("m_idx", {ex_rs_o, ex_rt_o, ex_rd_o, ex_funct_o}, {m.rs, m.rt, m.rd, m.funct});
        check("m_stall", stall_o, expStall);
        check("m_pc_write", pc_write_o, !expStall);
        check("m_ifid_write", ifid_write_o, !expStall);
        check("m_bubble_cnt", bubble_cnt_o, m.cnt);
    end

    task automatic setInstr(input bit regDst, input bit [1:0] aluOp, input bit aluSrc,
                            input bit regWrite, input bit memWrite, input bit memRead,
                            input bit memtoReg, input bit [4:0] rs, input bit [4:0] rt,
                            input bit [4:0] rd);
        id_RegDst_i   = regDst;
        id_ALUOp_i    = aluOp;
        id_ALUSrc_i   = aluSrc;
        id_RegWrite_i = regWrite;
        id_MemWrite_i = memWrite;
        id_MemRead_i  = memRead;
        id_MemtoReg_i = memtoReg;
        id_rs_i       = rs;
        id_rt_i       = rt;
        id_rd_i       = rd;
        id_funct_i    = 6'($urandom);
        id_rs_data_i  = $urandom;
        id_rt_data_i  = $urandom;
        id_imm_i      = $urandom;
    endtask

    task automatic doAdd(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd);
        setInstr(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rs, rt, rd);
    endtask

    task automatic doLw(input bit [4:0] rs, input bit [4:0] rt);
        setInstr(1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, rs, rt, 5'd0);
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        doLw(5'd1, 5'd5);
        repeat (2) cyc();
        check("rst_MemRead", ex_MemRead_o, 0);
        check("rst_rt", ex_rt_o, 0);
        check("rst_cnt", bubble_cnt_o, 0);
        check("rst_pc_write", pc_write_o, 1);

        rst_i = 1'b1;
        doAdd(5'd1, 5'd2, 5'd3);
        cyc();
        check("add_RegDst", ex_RegDst_o, 1);
        check("add_ALUOp", ex_ALUOp_o, 2'b10);
        check("add_RegWrite", ex_RegWrite_o, 1);
        check("add_rd", ex_rd_o, 3);

        doLw(5'd1, 5'd5);
        cyc();
        doAdd(5'd5, 5'd2, 5'd6);
        #1;
        check("lu_stall", stall_o, 1);
        check("lu_pc_write", pc_write_o, 0);
        check("lu_ifid_write", ifid_write_o, 0);
        cyc();
        check("lu_bub_RegWrite", ex_RegWrite_o, 0);
        check("lu_bub_MemRead", ex_MemRead_o, 0);
        check("lu_bub_cnt", bubble_cnt_o, 1);
        check("lu_bub_stall", stall_o, 0);
        cyc();
        check("lu_go_rs", ex_rs_o, 5);
        check("lu_go_rd", ex_rd_o, 6);
        check("lu_go_RegWrite", ex_RegWrite_o, 1);

        doLw(5'd1, 5'd0);
        cyc();
        doAdd(5'd0, 5'd0, 5'd7);
        #1;
        check("zero_stall", stall_o, 0);
        cyc();
        check("zero_RegWrite", ex_RegWrite_o, 1);
        check("zero_rd", ex_rd_o, 7);
        check("zero_cnt", bubble_cnt_o, 1);

        doLw(5'd1, 5'd7);
        cyc();
        doAdd(5'd7, 5'd3, 5'd8);
        flush_i = 1'b1;
        #1;
        check("fh_stall", stall_o, 0);
        cyc();
        check("fh_cnt", bubble_cnt_o, 2);
        check("fh_RegWrite", ex_RegWrite_o, 0);
        flush_i = 1'b0;

        doLw(5'd1, 5'd8);
        cyc();
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            doAdd(5'd8, 5'(i), 5'(10 + i));
            #1;
            check("hold_stall", stall_o, 0);
            cyc();
            check("hold_rt", ex_rt_o, 8);
            check("hold_MemRead", ex_MemRead_o, 1);
            check("hold_cnt", bubble_cnt_o, 2);
        end
        hold_i = 1'b0;
        doAdd(5'd8, 5'd2, 5'd12);
        #1;
        check("unhold_stall", stall_o, 1);
        cyc();
        check("unhold_cnt", bubble_cnt_o, 3);
        cyc();
        check("unhold_rd", ex_rd_o, 12);

        doLw(5'd1, 5'd9);
        cyc();
        doLw(5'd9, 5'd10);
        cyc();
        cyc();
        doAdd(5'd10, 5'd0, 5'd11);
        cyc();
        cyc();
        check("b2b_cnt", bubble_cnt_o, 5);
        check("b2b_rd", ex_rd_o, 11);

        doLw(5'd1, 5'd4);
        cyc();
        doAdd(5'd4, 5'd0, 5'd5);
        #1;
        check("mid_stall_pre", stall_o, 1);
        #2;
        rst_i = 1'b0;
        #1;
        check("mid_stall_post", stall_o, 0);
        check("mid_cnt", bubble_cnt_o, 0);
        check("mid_pc_write", pc_write_o, 1);
        cyc();
        rst_i = 1'b1;

        flush_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            doAdd(5'(i), 5'(i + 1), 5'(i + 2));
            cyc();
        end
        check("sat_cnt", bubble_cnt_o, 15);
        check("sat_RegWrite", ex_RegWrite_o, 0);
        flush_i = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
